// File: rtl/pwm_dac.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pwm_dac : windowed PWM DAC with one-entry pending code, hold-last-sample  |
// | Option macro: PWM_DAC_UNDERRUN_EN (adds underrun_count)    Rev 1.0        |
// +--------------------------------------------------------------------------+
module pwm_dac #(
  parameter int unsigned CYCLES_PER_WINDOW = 1024,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic                  pwm,
  output logic                  window_start
`ifdef PWM_DAC_UNDERRUN_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int unsigned      CNT_W      = $clog2(CYCLES_PER_WINDOW);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_WINDOW - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] code_clamped;
  logic             started_q;
  logic             pending_full_q, pending_full_d;
  logic             pwm_q, pwm_d;
  logic             window_start_q, window_start_d;
  logic             transfer;
  logic             wrap;

  always_comb begin
    transfer = code_valid && !pending_full_q;
    // The first edge after reset parks the counter at 0 to open window 0; it is not a wrap.
    wrap     = started_q && (count_q == LAST_COUNT);

    if (32'(code) > 32'(CYCLES_PER_WINDOW - 1)) begin
      code_clamped = LAST_COUNT;
    end else begin
      code_clamped = CNT_W'(code);
    end

    if (!started_q || wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end

    window_start_d = (count_d == '0);
    pwm_d          = (count_q < active_q);

    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (wrap && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (transfer) begin
      pending_d      = code_clamped;
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      started_q      <= 1'b0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      window_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      started_q      <= 1'b1;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      window_start_q <= window_start_d;
    end
  end

  assign code_ready   = !pending_full_q;
  assign pwm          = pwm_q;
  assign window_start = window_start_q;

`ifdef PWM_DAC_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (wrap && !pending_full_q && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac.sv
`default_nettype none
`timescale 1ns/1ps
// tb_pwm_dac : randomized and directed checks of pwm_dac against a window-level model.
module tb_pwm_dac;

  localparam int unsigned CPW = 8;
  localparam int unsigned CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          code_ready;
  logic          pwm;
  logic          window_start;
`ifdef PWM_DAC_UNDERRUN_EN
  logic [15:0]   underrun_count;
`endif

  int total = 0;
  int bad   = 0;

  // Window-level reference state: t counts edges since reset release,
  // m_duty is the number of high cycles owed in the current window.
  int t;
  bit m_pend_full;
  int m_pend_val;
  int m_duty;
  int m_under;
  bit exp_pwm;
  bit exp_ws;

  always #5 clk = ~clk;

  pwm_dac #(
    .CYCLES_PER_WINDOW(CPW),
    .CODE_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code(code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .pwm(pwm),
    .window_start(window_start)
`ifdef PWM_DAC_UNDERRUN_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t           = 0;
    m_pend_full = 1'b0;
    m_pend_val  = 0;
    m_duty      = 0;
    m_under     = 0;
    exp_pwm     = 1'b0;
    exp_ws      = 1'b0;
  endtask

  // One clock edge: a new window begins every CPW edges, taking the pending
  // code if there is one; pwm is high for positions 1..duty of each window.
  task automatic model_edge();
    bit xfer;
    int p;
    xfer = code_valid && !m_pend_full;
    t++;
    p = (t - 1) % CPW;
    if (t > 1 && p == 0) begin
      if (m_pend_full) begin
        m_duty      = m_pend_val;
        m_pend_full = 1'b0;
      end else if (m_under < 65535) begin
        m_under++;
      end
    end
    if (xfer) begin
      m_pend_full = 1'b1;
      m_pend_val  = (int'(code) > CPW - 1) ? CPW - 1 : int'(code);
    end
    exp_ws  = (p == 0);
    exp_pwm = (p >= 1) && (p <= m_duty);
  endtask

  task automatic check_outputs();
    check_val("pwm", pwm, exp_pwm);
    check_val("window_start", window_start, exp_ws);
    check_val("code_ready", code_ready, !m_pend_full);
`ifdef PWM_DAC_UNDERRUN_EN
    check_val("underrun_count", underrun_count, m_under);
`endif
  endtask

  task automatic step(input bit v, input int c);
    code_valid = v;
    code       = c[CW-1:0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  // Called just after a falling edge: reset lands mid-cycle so pwm must drop at once.
  task automatic do_reset(input int cycles);
    #2 rst = 1'b1;
    code_valid = 1'b0;
    #1;
    check_val("pwm_async_reset", pwm, 0);
    check_val("ready_in_reset", code_ready, 1);
    check_val("ws_in_reset", window_start, 0);
    model_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_val("pwm_held_reset", pwm, 0);
    check_val("ready_held_reset", code_ready, 1);
    check_val("ws_held_reset", window_start, 0);
`ifdef PWM_DAC_UNDERRUN_EN
    check_val("underrun_reset", underrun_count, 0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    code_valid = 1'b0;
    code       = '0;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Idle for three windows.
    idle(3 * CPW + 1);

    // Code 3 mid-window, then watch it play out.
    idle(3);
    step(1'b1, 3);
    idle(2 * CPW);

    // Code 5, then code 2 held valid until it is taken.
    step(1'b1, 5);
    repeat (CPW + 2) step(1'b1, 2);
    idle(2 * CPW);

    // Extremes 0 and 7.
    step(1'b1, 0);
    idle(2 * CPW);
    step(1'b1, 7);
    idle(2 * CPW);

    // Reset with an active and a pending code.
    step(1'b1, 6);
    idle(CPW + 1);
    step(1'b1, 4);
    step(1'b0, 0);
    do_reset(2);
    idle(3 * CPW);

    // One code, then several idle windows.
    step(1'b1, 3);
    idle(5 * CPW);

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, CPW - 1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
